// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared states, opcodes, select codes and control bundle for the multi-cycle control FSM
package mc_ctrl_pkg;
    localparam int OP_W = 6;
    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ADDI_EXEC = 4'd11,
        ADDI_WB   = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_op;
        logic       retire;
    } ctrl_t;

    // Dispatch target out of DECODE; FETCH doubles as the "unrecognised opcode" result.
    function automatic state_t dispatch(input logic [OP_W-1:0] op);
        case (op)
            OP_LW, OP_SW: return MEM_ADDR;
            OP_RTYPE:     return EXECUTE;
            OP_BEQ:       return BRANCH;
            OP_J:         return JUMP;
            OP_ADDI:      return ADDI_EXEC;
            default:      return FETCH;
        endcase
    endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: request/ready handshake to the shared instruction/data memory
interface multicycle_control_if;
    logic mem_req;
    logic mem_ready;
    logic mem_read;
    logic mem_write;
    logic i_or_d;

    modport master (output mem_req, mem_read, mem_write, i_or_d, input mem_ready);
    modport slave  (input mem_req, mem_read, mem_write, i_or_d, output mem_ready);
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state + mem_ready -> datapath control decode
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t          state,
    input  logic            mem_ready,
    input  logic [OP_W-1:0] opcode,
    output ctrl_t           ctrl
);
    // Moore decode; only the fetch latch strobes and the store retire follow mem_ready.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.illegal_op = dispatch(opcode) == FETCH;
            end
            MEM_ADDR, ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEM_READ: begin
                ctrl.mem_req  = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.retire    = mem_ready;
            end
            EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.retire        = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.retire    = 1'b1;
            end
            ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM sequencing fetch/decode/execute/memory/write-back
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_W-1:0]      opcode,
    multicycle_control_if.master mem,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_source,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 illegal_op,
    output logic                 retire,
    output logic [ST_W-1:0]      state_dbg
);
    state_t state, state_nxt;
    logic   is_store;
    ctrl_t  ctrl;

    // Next-state selection; opcode is consulted only in DECODE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:                         state_nxt = FETCH;
            FETCH:                        state_nxt = mem.mem_ready ? DECODE : FETCH;
            DECODE:                       state_nxt = dispatch(opcode);
            MEM_ADDR:                     state_nxt = is_store ? MEM_WRITE : MEM_READ;
            MEM_READ:                     state_nxt = mem.mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE:                    state_nxt = mem.mem_ready ? FETCH : MEM_WRITE;
            EXECUTE:                      state_nxt = R_WB;
            ADDI_EXEC:                    state_nxt = ADDI_WB;
            MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: state_nxt = FETCH;
            default:                      state_nxt = IDLE;
        endcase
    end

    // State register; is_store remembers lw vs sw past DECODE so later opcode changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            is_store <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == DECODE) is_store <= opcode == OP_SW;
        end
    end

    mc_ctrl_decode u_decode (
        .state     (state),
        .mem_ready (mem.mem_ready),
        .opcode    (opcode),
        .ctrl      (ctrl)
    );

    assign mem.mem_req   = ctrl.mem_req;
    assign mem.mem_read  = ctrl.mem_read;
    assign mem.mem_write = ctrl.mem_write;
    assign mem.i_or_d    = ctrl.i_or_d;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign illegal_op    = ctrl.illegal_op;
    assign retire        = ctrl.retire;
    assign state_dbg     = state;
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RISC datapath.
- Sequences instruction fetch, decode, execute, memory and write-back phases from the 6-bit opcode.
- Drives all datapath mux and enable selects, plus the 2-bit ALUOp consumed by ALU_control.
- Stalls on a ready/request handshake to the shared instruction/data memory.

Parameters:
- OP_W, 6, opcode width (instr[31:26]).
- ST_W, 4, state register width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OP_W  opcode from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  out  1  instruction register load.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- pc_source  out  2  PC mux: 00=ALU, 01=ALUOut, 10=jump target.
- alu_src_a  out  1  0=PC, 1=regA.
- alu_src_b  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- alu_op  out  2  00=add, 01=subtract, 10=use funct (matches ALU_control).
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALUOut, 1=MDR.
- reg_write  out  1  register file write enable.
- illegal_op  out  1  one-cycle flag for an unrecognised opcode.
- retire  out  1  one-cycle pulse when an instruction completes.
- state_dbg  out  ST_W  current state, for debug.

Behaviour:
- Moore FSM. Outputs are a combinational decode of the state register. mem_ready gates only the marked strobes below. Any output not listed for a state is 0.
- Reset: async assertion forces IDLE. In IDLE all outputs are 0. The first clock after rst_n deasserts moves IDLE -> FETCH.
- Reset asserted mid-instruction aborts immediately to IDLE; no write strobe may be asserted while rst_n=0.
- States and transitions:
  - IDLE: -> FETCH.
  - FETCH: mem_req=1, mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write = mem_ready. Stay while mem_ready=0; -> DECODE when mem_ready=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
    - 100011 lw or 101011 sw -> MEM_ADDR
    - 000000 R-type -> EXECUTE
    - 000100 beq -> BRANCH
    - 000010 j -> JUMP
    - 001000 addi -> ADDI_EXEC
    - other -> FETCH with illegal_op=1 in DECODE.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. -> MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ: mem_req=1, mem_read=1, i_or_d=1. Wait for mem_ready, then -> MEM_WB.
  - MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, retire=1. -> FETCH.
  - MEM_WRITE: mem_req=1, mem_write=1, i_or_d=1. Wait for mem_ready; retire=mem_ready. -> FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. -> R_WB.
  - R_WB: reg_dst=1, mem_to_reg=0, reg_write=1, retire=1. -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, retire=1. -> FETCH.
  - JUMP: pc_write=1, pc_source=10, retire=1. -> FETCH.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. -> ADDI_WB.
  - ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1, retire=1. -> FETCH.
- Latency with zero wait states (FETCH counted as one cycle):
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - Each cycle with mem_ready=0 adds one cycle.
- opcode is sampled only in DECODE; changes in other states are ignored.
- Unused state encodings -> IDLE (all outputs 0).
- mem_read and mem_write are never both 1.
- reg_write, mem_write, pc_write and ir_write are never asserted in the same cycle as illegal_op.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state enumeration (ST_W bits)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALUOp codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - alu_src_b and pc_source codes.
- One sub-module, mc_ctrl_decode: purely combinational state-plus-mem_ready -> control-output decode.
- The top level keeps the state register and next-state logic.

Test Plan:
- Reset then R-type (opcode 000000), mem_ready=1 -> states IDLE, FETCH, DECODE, EXECUTE, R_WB; alu_op=10 in EXECUTE; reg_dst=1 and reg_write=1 in R_WB; retire pulses once; back in FETCH.
- lw (100011) with mem_ready low for 2 cycles in MEM_READ -> MEM_READ held 3 cycles with mem_req=1, i_or_d=1; then MEM_WB with mem_to_reg=1, reg_write=1.
- beq (000100) -> BRANCH drives alu_op=01, pc_write_cond=1, pc_source=01; total 3 cycles; sw (101011) -> mem_write=1 only in MEM_WRITE.
- FETCH with mem_ready=0 for 4 cycles -> ir_write=0 and pc_write=0 throughout; on the ready cycle both are 1 for exactly one cycle.
- Opcode 111111 -> illegal_op=1 for one cycle in DECODE, no write strobes, next state FETCH.
- rst_n asserted asynchronously mid-MEM_WRITE -> mem_write drops without waiting for a clock edge, state_dbg=IDLE; after release, fetch restarts in 1 cycle.
